// File: rtl/clusterv_tile_sram_wb_initiator_if.sv
// Wishbone-classic target side plus OpenRAM-style single RW port, bundled so the
// initiator and its environment share one connection.
interface clusterv_tile_sram_wb_initiator_if #(
  parameter int ADDR_BITS = 8
);
  logic [31:0]          adr;
  logic [31:0]          dat_w;
  logic [31:0]          dat_r;
  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [3:0]           sel;
  logic                 ack;
  logic                 i_csb;
  logic                 i_web;
  logic [3:0]           i_wmask;
  logic [ADDR_BITS-1:0] i_addr;
  logic [31:0]          i_dat_w;
  logic [31:0]          i_dat_r;

  modport slave (
    input  adr, dat_w, cyc, stb, we, sel, i_dat_r,
    output dat_r, ack, i_csb, i_web, i_wmask, i_addr, i_dat_w
  );

  modport master (
    output adr, dat_w, cyc, stb, we, sel, i_dat_r,
    input  dat_r, ack, i_csb, i_web, i_wmask, i_addr, i_dat_w
  );
endinterface

// File: rtl/clusterv_tile_sram_wb_initiator.sv
// Turns each Wishbone-classic cycle into exactly one registered SRAM RW-port
// access, waiting READ_LATENCY clocks for synchronous read data.
module clusterv_tile_sram_wb_initiator #(
  parameter int ADDR_BITS    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  clusterv_tile_sram_wb_initiator_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 abort_q, abort_d;
  logic                 csb_q, csb_d;
  logic                 web_q, web_d;
  logic [3:0]           wmask_q, wmask_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          datw_q, datw_d;
  logic [31:0]          datr_q, datr_d;
  logic                 ack_q, ack_d;

  logic req;
  logic abort_now;
  logic unused_adr_bits;

  assign req       = bus.cyc & bus.stb;
  // A master that drops cyc at the completing edge aborts just like an earlier drop.
  assign abort_now = abort_q | ~bus.cyc;
  assign unused_adr_bits = ^{bus.adr[31:ADDR_BITS+2], bus.adr[1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      datw_q  <= '0;
      datr_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      datw_q  <= datw_d;
      datr_q  <= datr_d;
      ack_q   <= ack_d;
    end
  end

  // web_q is still low throughout ISSUE for a write, so it doubles as the access type.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = ISSUE;
      ISSUE:   if (!web_q) state_d = abort_now ? IDLE : RESP;
               else        state_d = WAIT;
      WAIT:    if (cnt_q == 2'd0) state_d = abort_now ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = '0;
    addr_d  = addr_q;
    datw_d  = datw_q;
    datr_d  = datr_q;
    ack_d   = 1'b0;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          csb_d   = 1'b0;
          web_d   = ~bus.we;
          wmask_d = bus.we ? bus.sel : 4'h0;
          addr_d  = bus.adr[ADDR_BITS+1:2];
          datw_d  = bus.dat_w;
          abort_d = 1'b0;
        end
      end
      ISSUE: begin
        if (!web_q) begin
          ack_d   = ~abort_now;
          abort_d = 1'b0;
        end else begin
          cnt_d   = CNT_INIT;
          abort_d = abort_now;
        end
      end
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d   = cnt_q - 2'd1;
          abort_d = abort_now;
        end else begin
          if (!abort_now) begin
            datr_d = bus.i_dat_r;
            ack_d  = 1'b1;
          end
          abort_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.i_csb   = csb_q;
  assign bus.i_web   = web_q;
  assign bus.i_wmask = wmask_q;
  assign bus.i_addr  = addr_q;
  assign bus.i_dat_w = datw_q;
  assign bus.dat_r   = datr_q;
  assign bus.ack     = ack_q;
endmodule

// File: tb/tb_clusterv_tile_sram_wb_initiator.sv
// Bench for the Wishbone-to-SRAM initiator: two instances (read latency 1 and 3),
// each with its own SRAM model, checked against a word-array reference model.
module tb_clusterv_tile_sram_wb_initiator;
  localparam int AB  = 8;
  localparam int RL0 = 1;
  localparam int RL1 = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  clusterv_tile_sram_wb_initiator_if #(.ADDR_BITS(AB)) bus0 ();
  clusterv_tile_sram_wb_initiator_if #(.ADDR_BITS(AB)) bus1 ();

  clusterv_tile_sram_wb_initiator #(.ADDR_BITS(AB), .READ_LATENCY(RL0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0));
  clusterv_tile_sram_wb_initiator #(.ADDR_BITS(AB), .READ_LATENCY(RL1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  logic          cyc_t [2];
  logic          stb_t [2];
  logic          we_t  [2];
  logic [31:0]   adr_t [2];
  logic [31:0]   dw_t  [2];
  logic [3:0]    sel_t [2];
  logic          ack_o [2];
  logic          csb_o [2];
  logic          web_o [2];
  logic [3:0]    wm_o  [2];
  logic [AB-1:0] addr_o[2];
  logic [31:0]   wdat_o[2];
  logic [31:0]   datr_o[2];
  logic [31:0]   rdat  [2];

  assign bus0.cyc = cyc_t[0];  assign bus1.cyc = cyc_t[1];
  assign bus0.stb = stb_t[0];  assign bus1.stb = stb_t[1];
  assign bus0.we  = we_t[0];   assign bus1.we  = we_t[1];
  assign bus0.adr = adr_t[0];  assign bus1.adr = adr_t[1];
  assign bus0.dat_w = dw_t[0]; assign bus1.dat_w = dw_t[1];
  assign bus0.sel = sel_t[0];  assign bus1.sel = sel_t[1];
  assign bus0.i_dat_r = rdat[0];
  assign bus1.i_dat_r = rdat[1];
  assign ack_o[0]  = bus0.ack;     assign ack_o[1]  = bus1.ack;
  assign csb_o[0]  = bus0.i_csb;   assign csb_o[1]  = bus1.i_csb;
  assign web_o[0]  = bus0.i_web;   assign web_o[1]  = bus1.i_web;
  assign wm_o[0]   = bus0.i_wmask; assign wm_o[1]   = bus1.i_wmask;
  assign addr_o[0] = bus0.i_addr;  assign addr_o[1] = bus1.i_addr;
  assign wdat_o[0] = bus0.i_dat_w; assign wdat_o[1] = bus1.i_dat_w;
  assign datr_o[0] = bus0.dat_r;   assign datr_o[1] = bus1.dat_r;

  // OpenRAM-style SRAM: samples at the clock edge, read data valid RL edges later.
  for (genvar g = 0; g < 2; g++) begin : g_sram
    localparam int RL = (g == 0) ? RL0 : RL1;
    logic [31:0] mem  [256];
    logic [31:0] pipe [4];
    initial for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    always @(posedge clock) begin
      for (int s = 3; s > 0; s--) pipe[s] <= pipe[s-1];
      if (csb_o[g] == 1'b0) begin
        if (web_o[g] == 1'b0) begin
          for (int b = 0; b < 4; b++)
            if (wm_o[g][b]) mem[addr_o[g]][8*b +: 8] <= wdat_o[g][8*b +: 8];
        end else begin
          pipe[0] <= mem[addr_o[g]];
        end
      end
    end
    assign rdat[g] = pipe[RL-1];
  end

  logic [31:0] ref_mem  [2][256];
  logic [31:0] ref_datr [2];
  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic ref_write(input int d, input logic [AB-1:0] wa, input logic [31:0] dat,
                           input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[d][wa][8*b +: 8] = dat[8*b +: 8];
  endtask

  // One Wishbone cycle on instance d; called at a negedge, returns at a negedge.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] dat,
                      input logic [3:0] s, input bit abort, input bit hold);
    int            lat;
    int            csb_cnt;
    int            exp_lat;
    bit            got;
    logic [AB-1:0] wa;
    wa      = a[AB+1:2];
    exp_lat = w ? 2 : 2 + ((d == 0) ? RL0 : RL1);
    cyc_t[d] = 1'b1; stb_t[d] = 1'b1; we_t[d] = w;
    adr_t[d] = a;    dw_t[d]  = dat;  sel_t[d] = s;
    @(posedge clock);
    got = 0; lat = 0; csb_cnt = 0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clock);
      if (csb_o[d] === 1'b0) begin
        csb_cnt++;
        chk("issue_web", web_o[d], !w);
        chk("issue_addr", addr_o[d], wa);
        chk("issue_wmask", wm_o[d], w ? s : 4'h0);
        if (w) chk("issue_wdata", wdat_o[d], dat);
      end
      if (k == 1 && abort) begin
        cyc_t[d] = 1'b0; stb_t[d] = 1'b0;
      end
      if (ack_o[d] === 1'b1) begin
        got = 1; lat = k;
      end
    end
    if (w) ref_write(d, wa, dat, s);
    if (abort) begin
      chk("abort_no_ack", got, 0);
      chk("abort_datr_hold", datr_o[d], ref_datr[d]);
    end else begin
      chk("ack_latency", lat, exp_lat);
      if (!w) ref_datr[d] = ref_mem[d][wa];
      chk(w ? "datr_hold_on_write" : "read_data", datr_o[d], ref_datr[d]);
      if (!hold) begin
        cyc_t[d] = 1'b0; stb_t[d] = 1'b0;
      end
      @(negedge clock);
      if (csb_o[d] === 1'b0) csb_cnt++;
      chk("ack_one_cycle", ack_o[d], 1'b0);
    end
    chk("csb_cycles", csb_cnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    int          d;
    for (int i = 0; i < 2; i++) begin
      cyc_t[i] = 1'b0; stb_t[i] = 1'b0; we_t[i] = 1'b0;
      adr_t[i] = '0;   dw_t[i]  = '0;   sel_t[i] = '0;
      ref_datr[i] = '0;
      for (int j = 0; j < 256; j++) ref_mem[i][j] = '0;
    end

    // Reset state
    #1 reset = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst_csb", csb_o[i], 1'b1);
      chk("rst_web", web_o[i], 1'b1);
      chk("rst_wmask", wm_o[i], 4'h0);
      chk("rst_addr", addr_o[i], '0);
      chk("rst_wdat", wdat_o[i], '0);
      chk("rst_datr", datr_o[i], '0);
      chk("rst_ack", ack_o[i], 1'b0);
    end
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Write then read, byte-masked write
    xfer(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
    xfer(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0);
    chk("t1_readback", datr_o[0], 32'hDEAD_BEEF);
    xfer(0, 1'b1, 32'h0000_0010, 32'h0000_5500, 4'b0010, 0, 0);
    xfer(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0);
    chk("t2_readback", datr_o[0], 32'hDEAD_55EF);

    // Back-to-back reads with stb held across the response
    xfer(0, 1'b1, 32'h0, 32'hA5A5_0001, 4'hF, 0, 0);
    xfer(0, 1'b1, 32'h4, 32'h5A5A_0002, 4'hF, 0, 0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1);
    chk("t3_first", datr_o[0], 32'hA5A5_0001);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 0);
    chk("t3_second", datr_o[0], 32'h5A5A_0002);

    // Longer read latency
    xfer(1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 0, 0);
    xfer(1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 0);
    chk("t4_readback", datr_o[1], 32'hCAFE_F00D);

    // Abort, then normal service
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 1, 0);
    xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 1, 0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, 0);

    // Randomized traffic, including aliasing addresses, empty selects and aborts
    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(0, 1));
      a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      s = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      xfer(d, 1'($urandom_range(0, 1)), a, $urandom, s, $urandom_range(0, 7) == 0, 0);
    end

    // Reset while the latency-3 instance is in WAIT
    cyc_t[1] = 1'b1; stb_t[1] = 1'b1; we_t[1] = 1'b0; adr_t[1] = 32'h40;
    @(posedge clock);
    @(negedge clock); @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst_csb", csb_o[1], 1'b1);
    chk("midrst_ack", ack_o[1], 1'b0);
    chk("midrst_datr", datr_o[1], '0);
    chk("midrst_datr0", datr_o[0], '0);
    cyc_t[1] = 1'b0; stb_t[1] = 1'b0;
    ref_datr[0] = '0; ref_datr[1] = '0;
    @(negedge clock);
    chk("midrst_csb_held", csb_o[1], 1'b1);
    chk("midrst_ack_held", ack_o[1], 1'b0);
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      xfer(i, 1'b1, 32'h0000_0080, 32'h1234_5678, 4'hF, 0, 0);
      xfer(i, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 0, 0);
      chk("t6_readback", datr_o[i], 32'h1234_5678);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/clusterv_tile_sram_wb_initiator.md
Name: clusterv_tile_sram_wb_initiator

Overview:
Wishbone-classic (B3, non-pipelined) target that acts as initiator on the tile SRAM RW port. The SRAM side is an OpenRAM-style single RW port: active-low chip select and write enable, 4-bit byte write mask, word address, and synchronous read data. The block sits between the tile interconnect and the tile SRAM instance, turning each Wishbone cycle into one SRAM access. It registers every SRAM-side output and counts the read latency.

Parameters:
ADDR_BITS, 8, SRAM word-address width; i_addr = adr[ADDR_BITS+1:2].
READ_LATENCY, 1, clocks from the SRAM sampling edge until i_dat_r is valid; legal range 1..4.

Ports:
clock  input  1  single clock for the block and the SRAM.
reset  input  1  asynchronous, active-low reset.
adr  input  32  Wishbone byte address; bits [1:0] ignored.
dat_w  input  32  Wishbone write data.
dat_r  output  32  Wishbone read data, registered.
cyc  input  1  Wishbone cycle.
stb  input  1  Wishbone strobe.
we  input  1  Wishbone write enable.
sel  input  4  Wishbone byte selects.
ack  output  1  Wishbone acknowledge, registered, one-cycle pulse.
i_csb  output  1  SRAM chip select, active low.
i_web  output  1  SRAM write enable, active low.
i_wmask  output  4  SRAM byte write mask.
i_addr  output  ADDR_BITS  SRAM word address.
i_dat_w  output  32  SRAM write data.
i_dat_r  input  32  SRAM read data.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, i_csb=1, i_web=1, i_wmask=0, i_addr=0, i_dat_w=0, dat_r=0, ack=0, wait counter=0, abort flag=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On a clock edge with cyc&stb=1, register i_csb=0, i_web=~we, i_addr=adr[ADDR_BITS+1:2], i_dat_w=dat_w.
  - i_wmask=sel for writes and 4'h0 for reads.
  - Next state is ISSUE.
- ISSUE (SRAM samples at the end of this cycle):
  - On the next edge set i_csb=1, i_web=1, i_wmask=0. i_addr and i_dat_w hold their values.
  - Write: next state RESP with ack<=1.
  - Read: next state WAIT with counter<=READ_LATENCY-1.
- WAIT:
  - If counter!=0, decrement.
  - If counter==0, set dat_r<=i_dat_r, ack<=1, next state RESP.
- RESP:
  - ack is high for exactly one cycle; on the next edge ack<=0 and state returns to IDLE.
  - The request is not resampled in RESP, so exactly one idle cycle separates back-to-back accesses.
- Latency from the edge that samples cyc&stb:
  - Write: ack is high in the 2nd cycle after that edge.
  - Read: ack is high in the (2+READ_LATENCY)th cycle; with the default this is the 3rd cycle.
- dat_r:
  - Updated only on read completion; holds its value otherwise, including across writes.
  - Undefined-by-protocol during writes, but it must not change.
- Abort:
  - If cyc==0 on any edge while in ISSUE or WAIT, set the abort flag.
  - The SRAM access still completes; the strobe is not retracted.
  - At completion, ack stays 0 and dat_r is not updated; state goes to IDLE and the abort flag clears.
- sel==0 write: the SRAM access is issued with wmask=0, memory is unchanged, and ack is still returned.
- Address bits above ADDR_BITS+1 are ignored, so addresses alias.
- Reset asserted mid-access: outputs go immediately to their reset values, no ack is produced, and the SRAM sees csb=1 from that point.
- At most one SRAM access is outstanding at any time.
- i_csb is low for exactly one cycle per access.

Test Plan:
1. Write, then read:
   - Stimulus: write adr=0x0000_0010, dat_w=0xDEAD_BEEF, sel=4'hF, then read adr=0x10.
   - Required: i_addr=0x04; i_wmask=4'hF during the write ISSUE cycle; write ack 2 cycles after request; read ack 3 cycles after request with dat_r=0xDEAD_BEEF.
2. Byte-masked write:
   - Stimulus: after test 1, write sel=4'b0010 with dat_w=0x0000_5500, then read.
   - Required: i_wmask=4'b0010; readback 0xDEAD_55EF.
3. Back-to-back reads:
   - Stimulus: read adr=0x0 then 0x4 with stb held high.
   - Required: two acks separated by ≥1 idle cycle; i_csb low exactly 1 cycle per access; correct data for each address.
4. READ_LATENCY=3:
   - Stimulus: read with READ_LATENCY=3.
   - Required: ack appears 5 cycles after request; dat_r equals i_dat_r as sampled at that edge.
5. Abort:
   - Stimulus: drop cyc in the cycle after the read request.
   - Required: no ack; dat_r unchanged from its previous value; the next valid request is serviced normally.
6. Reset mid-read:
   - Stimulus: assert reset (low) asynchronously while in WAIT.
   - Required: i_csb=1, ack=0, dat_r=0 immediately, with no clock edge needed; after release, a write then read of 0x1234_5678 succeeds.
